divisor_sequencial: RTL and testbench

DIVISOR_SEQUENCIAL -- requirements
Module: divisor_sequencial

---
 rtl/divisor_pkg.sv | 13 +
 rtl/passo_divisao.sv | 22 ++
 rtl/divisor_sequencial.sv | 112 +++++++++++
 tb/tb_divisor_sequencial.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// rtl/divisor_pkg.sv - shared widths and FSM states for the sequential divider
package divisor_pkg;

    localparam int N_WIDTH_DEF = 8;
    localparam int D_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/passo_divisao.sv
// rtl/passo_divisao.sv - one combinational restoring-division step
module passo_divisao #(
    parameter int D_WIDTH = divisor_pkg::D_WIDTH_DEF
) (
    input  logic [D_WIDTH:0]   rem_i,
    input  logic               bit_i,
    input  logic [D_WIDTH-1:0] divisor_i,
    output logic [D_WIDTH:0]   rem_o,
    output logic               q_o
);

    logic [D_WIDTH+1:0] shifted;
    logic [D_WIDTH:0]   diff;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in D_WIDTH+1 bits; the extra bit only keeps the compare exact.
    assign shifted = {rem_i, bit_i};
    assign q_o     = (shifted >= {2'b00, divisor_i});
    assign diff    = shifted[D_WIDTH:0] - {1'b0, divisor_i};
    assign rem_o   = q_o ? diff : shifted[D_WIDTH:0];

endmodule

// File: rtl/divisor_sequencial.sv
// rtl/divisor_sequencial.sv - multi-cycle restoring unsigned divider, one quotient bit per clock
module divisor_sequencial
    import divisor_pkg::*;
#(
    parameter int N_WIDTH = N_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [N_WIDTH-1:0] dividend_i,
    input  logic [D_WIDTH-1:0] divisor_i,
    output logic [N_WIDTH-1:0] quotient_o,
    output logic [D_WIDTH-1:0] remainder_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               div_by_zero_o
);

    localparam int CW = $clog2(N_WIDTH) + 1;
    localparam int IW = $clog2(N_WIDTH);

    state_t             state_q;
    logic [N_WIDTH-1:0] dividend_q;
    logic [D_WIDTH-1:0] divisor_q;
    logic [D_WIDTH:0]   rem_q;
    logic [N_WIDTH-1:0] quo_q;
    logic [CW-1:0]      count_q;
    logic [N_WIDTH-1:0] quotient_q;
    logic [D_WIDTH-1:0] remainder_q;
    logic               done_q;
    logic               dz_q;

    logic [IW-1:0]      bit_idx;
    logic [D_WIDTH:0]   rem_d;
    logic               qbit_d;
    logic [N_WIDTH-1:0] quo_d;

    // Counter runs N_WIDTH..1, so count-1 addresses dividend bits MSB first.
    assign bit_idx = IW'(count_q - CW'(1));

    passo_divisao #(.D_WIDTH(D_WIDTH)) u_passo (
        .rem_i     (rem_q),
        .bit_i     (dividend_q[bit_idx]),
        .divisor_i (divisor_q),
        .rem_o     (rem_d),
        .q_o       (qbit_d)
    );

    always_comb begin
        quo_d          = quo_q;
        quo_d[bit_idx] = qbit_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        dividend_q <= dividend_i;
                        divisor_q  <= divisor_i;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        count_q    <= CW'(N_WIDTH);
                        if (divisor_i == '0) begin
                            state_q     <= DONE;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dz_q        <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            dz_q    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q     <= DONE;
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d[D_WIDTH-1:0];
                        done_q      <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// tb/tb_divisor_sequencial.sv - self-checking bench for divisor_sequencial
module tb_divisor_sequencial;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [D-1:0] divisor;
    logic [N-1:0] quotient;
    logic [D-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dz;

    int checks   = 0;
    int failures = 0;

    divisor_sequencial #(.N_WIDTH(N), .D_WIDTH(D)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: latency counted in clock edges from the start edge, inclusive.
    task automatic model(input int a, input int b, output int q, output int r, output int z, output int lat);
        if (b == 0) begin
            q = (1 << N) - 1; r = 0; z = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 0; lat = N + 1;
        end
    endtask

    task automatic do_op(input int a, input int b, input string tag);
        int eq, er, ez, el, lat;
        model(a, b, eq, er, ez, el);
        @(negedge clk);
        start = 1'b1; dividend = N'(a); divisor = D'(b);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("%s %0d/%0d latency", tag, a, b), lat, el);
        chk($sformatf("%s %0d/%0d quotient", tag, a, b), {24'd0, quotient}, eq);
        chk($sformatf("%s %0d/%0d remainder", tag, a, b), {28'd0, remainder}, er);
        chk($sformatf("%s %0d/%0d div_by_zero", tag, a, b), {31'd0, dz}, ez);
        @(posedge clk); #1;
        chk($sformatf("%s %0d/%0d done one cycle", tag, a, b), {31'd0, done}, 0);
    endtask

    initial begin
        int pulses, cyc, qs, rs;

        // Reset asserted together with start: reset must win
        rst = 1'b1; start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset quotient", {24'd0, quotient}, 0);
        chk("reset remainder", {28'd0, remainder}, 0);
        chk("reset div_by_zero", {31'd0, dz}, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        do_op(200, 7, "basic");
        repeat (3) @(posedge clk);
        #1;
        chk("hold quotient", {24'd0, quotient}, 28);
        chk("hold remainder", {28'd0, remainder}, 4);
        do_op(255, 1, "max");
        do_op(5, 9, "small");
        do_op(100, 0, "divzero");
        do_op(100, 3, "after_divzero");
        do_op(0, 15, "zero_dividend");

        // Start pulsed during CALC must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 8'd9; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; qs = 0; rs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++; qs = int'(quotient); rs = int'(remainder);
            end
        end
        chk("ignore start pulses", pulses, 1);
        chk("ignore start quotient", qs, 28);
        chk("ignore start remainder", rs, 4);

        // Reset in the fourth CALC cycle aborts the operation
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort done", {31'd0, done}, 0);
        chk("abort quotient", {24'd0, quotient}, 0);
        chk("abort remainder", {28'd0, remainder}, 0);
        chk("abort div_by_zero", {31'd0, dz}, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        chk("abort no done", pulses, 0);

        // start held high: one result every N+2 cycles
        @(negedge clk);
        start = 1'b1; dividend = 8'd60; divisor = 4'd7;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (done !== 1'b1 && cyc < 40);
        chk("stream first done seen", {31'd0, done}, 1);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (done !== 1'b1 && cyc < 40);
        chk("stream period", cyc, N + 2);
        chk("stream quotient", {24'd0, quotient}, 8);
        chk("stream remainder", {28'd0, remainder}, 4);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (busy !== 1'b0 && cyc < 40);
        chk("stream drains", {31'd0, busy}, 0);

        // Randomized operands
        for (int i = 0; i < 100; i++)
            do_op(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)), "rand");

        // Exhaustive sweep
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                do_op(a, b, "sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
